// File: rtl/list_collector.sv
// list_collector: four-phase req/ack sink that buffers a producer's list output.
// Optional phase watchdog enabled by defining LIST_COLLECTOR_TIMEOUT_EN.
module list_collector #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1000000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  input  logic                     start,
  output logic                     dfd_ready,
  input  logic                     dfd_done,
  output logic                     req,
  input  logic                     ack,
  input  logic [WIDTH-1:0]         value_0,
  input  logic [WIDTH-1:0]         value_1,
  input  logic [WIDTH-1:0]         value_2,
  input  logic                     value_0_valid,
  input  logic                     value_1_valid,
  input  logic                     value_2_valid,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               count,
  output logic [WIDTH+7:0]         sum,
  output logic [2:0]               status,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int XW = PW + 2;
  localparam int SW = WIDTH + 8;

  typedef enum logic [2:0] {
    S_IDLE, S_READY, S_REQ, S_DROP, S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]  ptr_q, ptr_d;
  logic [7:0]     count_q, count_d;
  logic [SW-1:0]  sum_q, sum_d;
  logic [2:0]     status_q, status_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           full_q, full_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [2:0][WIDTH-1:0] vals;
  logic [2:0]            we;
  logic [2:0][AW-1:0]    waddr;
  logic [1:0]            nval;
  logic [8:0]            cnt_sum;
  logic [XW-1:0]         pos;
  logic                  latch;
  logic                  tmo;
  logic                  tmo_hit;

  assign vals = {value_2, value_1, value_0};

  // Only the leading run of set flags counts as chunk data.
  always_comb begin
    nval = 2'd0;
    if (value_0_valid) begin
      nval = 2'd1;
      if (value_1_valid) begin
        nval = 2'd2;
        if (value_2_valid) nval = 2'd3;
      end
    end
  end

  assign latch   = (state_q == S_REQ) && ack;
  assign tmo_hit = tmo && (((state_q == S_REQ) && !ack) ||
                           ((state_q == S_DROP) && ack));

`ifdef LIST_COLLECTOR_TIMEOUT_EN
  logic [31:0] tcnt_q, tcnt_d;
  logic        in_phase;

  assign in_phase = (state_d == S_REQ) || (state_d == S_DROP);

  always_comb begin
    tcnt_d = tcnt_q + 32'd1;
    if (!in_phase || (state_d != state_q)) tcnt_d = '0;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) tcnt_q <= '0;
    else          tcnt_q <= tcnt_d;
  end

  assign tmo = (tcnt_q >= 32'(TIMEOUT));
`else
  assign tmo = (TIMEOUT < 0);
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_READY;
      S_READY: state_d = S_REQ;
      S_REQ: begin
        if (ack)      state_d = S_DROP;
        else if (tmo) state_d = S_FIN;
      end
      S_DROP: begin
        if (!ack)     state_d = full_q ? S_REQ : S_FIN;
        else if (tmo) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req       = (state_q == S_REQ);
    dfd_ready = (state_q == S_READY);
  end

  always_comb begin
    count_d  = count_q;
    sum_d    = sum_q;
    status_d = status_q;
    ptr_d    = ptr_q;
    busy_d   = busy_q;
    done_d   = done_q;
    full_d   = full_q;
    we       = '0;
    waddr    = '0;
    cnt_sum  = '0;
    pos      = '0;
    if ((state_q == S_IDLE) && start) begin
      count_d  = '0;
      sum_d    = '0;
      status_d = '0;
      ptr_d    = '0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
    end
    if (state_q == S_FIN) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    if (busy_q && dfd_done) status_d[2] = 1'b1;
    if (tmo_hit)            status_d[1] = 1'b1;
    if (latch) begin
      full_d  = (nval == 2'd3);
      cnt_sum = 9'(count_q) + 9'(nval);
      count_d = cnt_sum[8] ? 8'hff : cnt_sum[7:0];
      for (int i = 0; i < 3; i++) begin
        if (i < int'(nval)) begin
          sum_d = sum_d + SW'(vals[i]);
          pos   = XW'(ptr_q) + XW'(i);
          if (pos < XW'(DEPTH)) begin
            we[i]    = 1'b1;
            waddr[i] = pos[AW-1:0];
          end else begin
            status_d[0] = 1'b1;
          end
        end
      end
      // Pointer parks at DEPTH once full; it never wraps.
      pos   = XW'(ptr_q) + XW'(nval);
      ptr_d = (pos > XW'(DEPTH)) ? PW'(DEPTH) : pos[PW-1:0];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q    <= '0;
      count_q  <= '0;
      sum_q    <= '0;
      status_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      status_q <= status_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    for (int i = 0; i < 3; i++) begin
      if (we[i]) mem_q[waddr[i]] <= vals[i];
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign count   = count_q;
  assign sum     = sum_q;
  assign status  = status_q;
  assign rd_data = mem_q[rd_addr];

endmodule

// File: doc/list_collector.md
# list_collector

Downstream consumer for a list-producing dataflow unit (`dfd_*` with list outputs). It starts the producer, pulls the list chunk by chunk over the four-phase `req`/`ack` handshake, and buffers up to `DEPTH` elements. It reports element count, running sum and completion to the top level (LEDs or a host). The block replaces the free-running request toggler in board-level list benches with a protocol-correct sink.

## Interface
- `WIDTH`, 8: element width in bits.
- `DEPTH`, 16: buffer entries, power of two, 4..256.
- `TIMEOUT`, 1000000: cycles allowed per handshake phase. Used only with `LIST_COLLECTOR_TIMEOUT_EN`.

Ports:
- `CLOCK_50`  in  1: sole clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse that begins a collection; ignored unless idle.
- `dfd_ready`  out  1: start strobe to the producer's ready input.
- `dfd_done`  in  1: producer done; informational, latched into `status[2]`.
- `req`  out  1: request for the next chunk.
- `ack`  in  1: producer chunk acknowledge.
- `value_0`, `value_1`, `value_2`  in  `WIDTH` each: chunk elements, in list order.
- `value_0_valid`, `value_1_valid`, `value_2_valid`  in  1 each: element-present flags, prefix-coded.
- `busy`  out  1: collection in progress.
- `done`  out  1: collection finished; held until next `start`.
- `count`  out  8: elements received, saturating at 255.
- `sum`  out  `WIDTH+8`: modulo sum of all received elements.
- `status`  out  3: bit 0 overflow, bit 1 timeout, bit 2 `dfd_done` seen.
- `rd_addr`  in  `$clog2(DEPTH)`: buffer read address.
- `rd_data`  out  `WIDTH`: buffer contents at `rd_addr`, combinational read.

## Operation
- **Reset values:**
  - All outputs are 0, including `req`, `dfd_ready`, `busy`, `done`, `count`, `sum` and `status`.
  - State is IDLE.
  - Buffer contents are undefined.
- **IDLE**
  - On `start`: clear `count`, `sum`, `status`; `done` goes to 0, `busy` goes to 1.
  - Pulse `dfd_ready` for exactly 1 cycle, then go to REQ.
- **REQ**
  - Hold `req`=1.
  - When `ack`=1 is sampled, the block latches the chunk on that edge:
    - Each valid element is appended to the buffer in order `value_0`, `value_1`, `value_2`.
    - `count` increases by the number of valid elements.
    - `sum` increases by the sum of the valid elements.
  - Then go to DROP.
- **DROP**
  - Hold `req`=0 and wait for `ack`=0.
  - If the last latched chunk had all three valid flags set, go to REQ.
  - Otherwise go to FINISH; the short chunk is the end-of-list marker, and an all-invalid chunk is legal.
- **FINISH**
  - For one cycle: `busy` goes to 0, `done` goes to 1. Then go to IDLE.
- **Prefix rule:** valid flags must be prefix-coded (`value_2_valid` implies `value_1_valid` implies `value_0_valid`). On a violation, only the leading run of set flags counts, and the chunk is treated as final.
- **Buffer:**
  - The write pointer starts at 0 on each `start`.
  - Elements past `DEPTH` are not stored. They set `status[0]` but still update `count` and `sum`.
  - The pointer never wraps.
- **Count:** saturates at 255; `sum` wraps modulo 2^(`WIDTH+8`).
- **`dfd_done`:** sampled every cycle while `busy`; a 1 sets `status[2]`.
- **`start` while busy:** ignored; no restart and no effect on state.
- **Reset mid-collection:** immediate return to IDLE; `req` drops asynchronously.

## Timing
- `dfd_ready` is high in the cycle after `start` is sampled; `req` rises the following cycle.
- Chunk latch happens on the first edge with `ack`=1 in REQ. `req` falls 1 cycle later, since it is registered.
- Minimum handshake is 4 cycles per chunk when `ack` follows `req` with zero delay.
- `done` rises 2 cycles after `ack`=0 is sampled on the final chunk (DROP to FINISH, then output registered).
- `count`, `sum` and the buffer are valid from the cycle `done` rises.
- `rd_data` has zero latency from `rd_addr`.
- All inputs are sampled synchronously to `CLOCK_50`; `ack` and the values must be stable while `ack`=1.

## Configuration
- **`LIST_COLLECTOR_TIMEOUT_EN` defined:**
  - A 32-bit phase counter resets on every REQ or DROP entry.
  - If it reaches `TIMEOUT` while in REQ or DROP, the block sets `status[1]`, drops `req`, and goes to FINISH.
  - Partial results are retained.
- **Macro undefined:** no counter; REQ and DROP wait indefinitely; `status[1]` is tied to 0.

## Test plan
- Chunks {1,2,3} {4,5,6} {7,-,-}, valid 111/111/100 → `count`=7, `sum`=28, buffer[0..6]=1..7, `status`=000, `done`=1.
- First chunk valid 000 → `done` 6 cycles after `start` with zero-delay `ack`; `count`=0, `sum`=0, no buffer writes.
- `DEPTH`=4, six full chunks then 000, each element 0xFF → `count`=18, `sum`=18×255=4590, buffer[0..3]=0xFF, `status[0]`=1.
- `start` pulsed every cycle during a collection, `ack` delayed 5 cycles → exactly one `dfd_ready` pulse; results equal the single-start case.
- `reset_n` asserted low while `req`=1 → `req`, `busy`, `count` are 0 immediately, before the next edge. After release, `start` runs a clean collection.
- With `LIST_COLLECTOR_TIMEOUT_EN` and `TIMEOUT`=20, `ack` never rises → `status[1]`=1, `done` rises about 22 cycles after `req`, `count`=0. Without the macro, `busy` remains 1 after 1000 cycles.
